// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline register of the pipelined processor. It sits directly
// downstream of the 32-bit ALU. It registers the ALU result and the EX control
// bundle into the MEM stage, and it honours stall and flush from the hazard
// unit.
//
// A signed overflow on a trapping add/sub becomes a precise exception. The
// offending instruction is squashed, so it never writes a register or memory.
// Its PC is captured in epc, and trap_req stays high until the control unit
// acknowledges the trap.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   stall, flush          hazard-unit controls (flush wins over stall)
//   ex_*                  EX-stage instruction: valid, pc, rd, controls, store data
//   alu_out, alu_ovf      ALU result and MSB-slice signed-overflow flag
//   alu_ctl               ALU control code (0010 add, 0110 sub)
//   ovf_trap_en           instruction is a trapping signed op
//   exc_ack               control unit has taken the trap
//   mem_*                 registered MEM-stage copy; controls are 0 in a bubble
//   exc_ovf               one-cycle pulse on trap entry
//   trap_req              level, high for the whole TRAP state
//   epc                   PC of the squashed overflowing instruction
//   ovf_cnt               saturating count of overflow traps taken
// -----------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int XLEN   = 32,
    parameter int RWIDTH = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   alu_out,
    input  logic              alu_ovf,
    input  logic [3:0]        alu_ctl,
    input  logic              ovf_trap_en,
    input  logic [RWIDTH-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_memtoreg,
    input  logic [XLEN-1:0]   ex_store_data,
    input  logic              exc_ack,
    output logic              mem_valid,
    output logic [XLEN-1:0]   mem_alu_out,
    output logic [RWIDTH-1:0] mem_rd,
    output logic              mem_regwrite,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic [XLEN-1:0]   mem_store_data,
    output logic              exc_ovf,
    output logic              trap_req,
    output logic [XLEN-1:0]   epc,
    output logic [CNT_W-1:0]  ovf_cnt
);

    localparam logic [3:0]       ALU_ADD = 4'b0010;
    localparam logic [3:0]       ALU_SUB = 4'b0110;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Stage action chosen for this cycle. When neither load nor bubble is
    // set, every mem_* register holds.
    logic load_s;
    logic bubble_s;
    logic take_trap_s;
    logic hit_s;

    logic              mem_valid_r;
    logic [XLEN-1:0]   mem_alu_out_r;
    logic [RWIDTH-1:0] mem_rd_r;
    logic              mem_regwrite_r;
    logic              mem_memread_r;
    logic              mem_memwrite_r;
    logic              mem_memtoreg_r;
    logic [XLEN-1:0]   mem_store_data_r;
    logic              exc_ovf_r;
    logic              trap_req_r;
    logic [XLEN-1:0]   epc_r;
    logic [CNT_W-1:0]  ovf_cnt_r;

    // Only a valid trapping add/sub that overflowed raises the exception.
    // An overflow flag on addu, slt or a logic op has no effect.
    assign hit_s = ex_valid & ovf_trap_en & alu_ovf &
                   ((alu_ctl == ALU_ADD) | (alu_ctl == ALU_SUB));

    // Next-state and stage-action decode: flush > stall > normal in RUN.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        bubble_s    = 1'b0;
        take_trap_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    bubble_s = 1'b1;
                end else if (stall) begin
                    // The instruction is re-presented later, so a hit is ignored now.
                    bubble_s = 1'b0;
                end else if (hit_s) begin
                    // Squash the overflowing instruction so it never writes back.
                    bubble_s    = 1'b1;
                    take_trap_s = 1'b1;
                    state_nxt_s = ST_TRAP;
                end else begin
                    load_s = 1'b1;
                end
            end
            ST_TRAP: begin
                // EX inputs, stall and flush are all ignored while trapping.
                // The instruction in the ack cycle is discarded as well.
                bubble_s = 1'b1;
                if (exc_ack) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_TRAP;
                end
            end
            default: begin
                bubble_s    = 1'b1;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEM-stage pipeline registers: load, bubble (data holds) or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r      <= 1'b0;
            mem_alu_out_r    <= {XLEN{1'b0}};
            mem_rd_r         <= {RWIDTH{1'b0}};
            mem_regwrite_r   <= 1'b0;
            mem_memread_r    <= 1'b0;
            mem_memwrite_r   <= 1'b0;
            mem_memtoreg_r   <= 1'b0;
            mem_store_data_r <= {XLEN{1'b0}};
        end else if (load_s) begin
            // Controls are gated by ex_valid so that they read 0 whenever mem_valid is 0.
            mem_valid_r      <= ex_valid;
            mem_alu_out_r    <= alu_out;
            mem_rd_r         <= ex_rd;
            mem_regwrite_r   <= ex_regwrite & ex_valid;
            mem_memread_r    <= ex_memread  & ex_valid;
            mem_memwrite_r   <= ex_memwrite & ex_valid;
            mem_memtoreg_r   <= ex_memtoreg & ex_valid;
            mem_store_data_r <= ex_store_data;
        end else if (bubble_s) begin
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            mem_memwrite_r <= 1'b0;
            mem_memtoreg_r <= 1'b0;
        end else begin
            mem_valid_r    <= mem_valid_r;
            mem_regwrite_r <= mem_regwrite_r;
            mem_memread_r  <= mem_memread_r;
            mem_memwrite_r <= mem_memwrite_r;
            mem_memtoreg_r <= mem_memtoreg_r;
        end
    end

    // Trap outputs: entry pulse, trap level, captured PC and saturating counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_ovf_r  <= 1'b0;
            trap_req_r <= 1'b0;
            epc_r      <= {XLEN{1'b0}};
            ovf_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            exc_ovf_r  <= take_trap_s;
            // Registered copy of the next state, so the level covers the whole TRAP state.
            trap_req_r <= (state_nxt_s == ST_TRAP);
            if (take_trap_s) begin
                epc_r <= ex_pc;
                if (ovf_cnt_r != CNT_MAX) begin
                    ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
                end else begin
                    ovf_cnt_r <= ovf_cnt_r;
                end
            end else begin
                epc_r     <= epc_r;
                ovf_cnt_r <= ovf_cnt_r;
            end
        end
    end

    assign mem_valid      = mem_valid_r;
    assign mem_alu_out    = mem_alu_out_r;
    assign mem_rd         = mem_rd_r;
    assign mem_regwrite   = mem_regwrite_r;
    assign mem_memread    = mem_memread_r;
    assign mem_memwrite   = mem_memwrite_r;
    assign mem_memtoreg   = mem_memtoreg_r;
    assign mem_store_data = mem_store_data_r;
    assign exc_ovf        = exc_ovf_r;
    assign trap_req       = trap_req_r;
    assign epc            = epc_r;
    assign ovf_cnt        = ovf_cnt_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Directed bench for ex_mem_stage. One instance uses the default parameters.
// A second instance has CNT_W=2 so that counter saturation can be seen, and
// both instances share all inputs. Inputs change 1 ns after each rising edge,
// and outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] alu_out;
    logic        alu_ovf;
    logic [3:0]  alu_ctl;
    logic        ovf_trap_en;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_memtoreg;
    logic [31:0] ex_store_data;
    logic        exc_ack;

    logic        mem_valid;
    logic [31:0] mem_alu_out;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_memread;
    logic        mem_memwrite;
    logic        mem_memtoreg;
    logic [31:0] mem_store_data;
    logic        exc_ovf;
    logic        trap_req;
    logic [31:0] epc;
    logic [7:0]  ovf_cnt;

    logic        s_mem_valid;
    logic [31:0] s_mem_alu_out;
    logic [4:0]  s_mem_rd;
    logic        s_mem_regwrite;
    logic        s_mem_memread;
    logic        s_mem_memwrite;
    logic        s_mem_memtoreg;
    logic [31:0] s_mem_store_data;
    logic        s_exc_ovf;
    logic        s_trap_req;
    logic [31:0] s_epc;
    logic [1:0]  s_ovf_cnt;

    int total = 0;
    int bad   = 0;

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_out(alu_out), .alu_ovf(alu_ovf),
        .alu_ctl(alu_ctl), .ovf_trap_en(ovf_trap_en), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_store_data(ex_store_data), .exc_ack(exc_ack),
        .mem_valid(mem_valid), .mem_alu_out(mem_alu_out), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
        .mem_store_data(mem_store_data), .exc_ovf(exc_ovf),
        .trap_req(trap_req), .epc(epc), .ovf_cnt(ovf_cnt)
    );

    ex_mem_stage #(.XLEN(32), .RWIDTH(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_out(alu_out), .alu_ovf(alu_ovf),
        .alu_ctl(alu_ctl), .ovf_trap_en(ovf_trap_en), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_store_data(ex_store_data), .exc_ack(exc_ack),
        .mem_valid(s_mem_valid), .mem_alu_out(s_mem_alu_out), .mem_rd(s_mem_rd),
        .mem_regwrite(s_mem_regwrite), .mem_memread(s_mem_memread),
        .mem_memwrite(s_mem_memwrite), .mem_memtoreg(s_mem_memtoreg),
        .mem_store_data(s_mem_store_data), .exc_ovf(s_exc_ovf),
        .trap_req(s_trap_req), .epc(s_epc), .ovf_cnt(s_ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_pc = 32'h0;
        alu_out = 32'h0; alu_ovf = 1'b0; alu_ctl = 4'b0010; ovf_trap_en = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
        ex_memtoreg = 1'b0; ex_store_data = 32'h0; exc_ack = 1'b0;
    endtask

    // Present a trapping add that overflows.
    task automatic ovf_add(input logic [31:0] pc);
        ex_valid = 1'b1; ex_pc = pc; alu_out = 32'h8000_0000; alu_ovf = 1'b1;
        alu_ctl = 4'b0010; ovf_trap_en = 1'b1; ex_rd = 5'd10; ex_regwrite = 1'b1;
        ex_memwrite = 1'b0;
    endtask

    initial begin
        logic [31:0] sat_exp [5];
        sat_exp[0] = 32'd1; sat_exp[1] = 32'd2; sat_exp[2] = 32'd3;
        sat_exp[3] = 32'd3; sat_exp[4] = 32'd3;

        // ---- reset ----
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid",    32'(mem_valid),    32'd0);
        chk("rst_regwrite", 32'(mem_regwrite), 32'd0);
        chk("rst_alu_out",  mem_alu_out,       32'd0);
        chk("rst_trap_req", 32'(trap_req),     32'd0);
        chk("rst_exc_ovf",  32'(exc_ovf),      32'd0);
        chk("rst_epc",      epc,               32'd0);
        chk("rst_cnt",      32'(ovf_cnt),      32'd0);
        rst = 1'b0;

        // ---- pass-through add ----
        ex_valid = 1'b1; ex_pc = 32'h40; alu_out = 32'h5; alu_ovf = 1'b0;
        alu_ctl = 4'b0010; ovf_trap_en = 1'b1; ex_rd = 5'd8; ex_regwrite = 1'b1;
        tick();
        chk("pt_valid",    32'(mem_valid),    32'd1);
        chk("pt_alu_out",  mem_alu_out,       32'd5);
        chk("pt_rd",       32'(mem_rd),       32'd8);
        chk("pt_regwrite", 32'(mem_regwrite), 32'd1);
        chk("pt_trap_req", 32'(trap_req),     32'd0);

        // ---- overflow trap ----
        ovf_add(32'h100);
        tick();
        chk("ovf_valid",    32'(mem_valid),    32'd0);
        chk("ovf_regwrite", 32'(mem_regwrite), 32'd0);
        chk("ovf_exc",      32'(exc_ovf),      32'd1);
        chk("ovf_trap_req", 32'(trap_req),     32'd1);
        chk("ovf_epc",      epc,               32'h100);
        chk("ovf_cnt",      32'(ovf_cnt),      32'd1);
        chk("ovf_alu_hold", mem_alu_out,       32'd5);

        // A valid sw in TRAP must be discarded.
        ex_valid = 1'b1; ex_pc = 32'h104; alu_out = 32'h2000; alu_ovf = 1'b0;
        ex_regwrite = 1'b0; ex_memwrite = 1'b1; ex_store_data = 32'hCAFE_F00D;
        tick();
        chk("trap_exc_pulse", 32'(exc_ovf),      32'd0);
        chk("trap_level",     32'(trap_req),     32'd1);
        chk("trap_memwrite",  32'(mem_memwrite), 32'd0);
        chk("trap_valid",     32'(mem_valid),    32'd0);
        chk("trap_epc_hold",  epc,               32'h100);

        // Ack is sampled two cycles after trap entry.
        exc_ack = 1'b1;
        tick();
        chk("ack_trap_req", 32'(trap_req),     32'd0);
        chk("ack_discard",  32'(mem_valid),    32'd0);
        chk("ack_memwrite", 32'(mem_memwrite), 32'd0);

        // ---- addu overflow: no trap; exc_ack in RUN is ignored ----
        ex_valid = 1'b1; ex_pc = 32'h200; alu_out = 32'h8000_0000; alu_ovf = 1'b1;
        alu_ctl = 4'b0010; ovf_trap_en = 1'b0; ex_rd = 5'd9; ex_regwrite = 1'b1;
        ex_memwrite = 1'b0; exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("addu_valid",    32'(mem_valid),    32'd1);
        chk("addu_alu_out",  mem_alu_out,       32'h8000_0000);
        chk("addu_regwrite", 32'(mem_regwrite), 32'd1);
        chk("addu_trap_req", 32'(trap_req),     32'd0);
        chk("addu_cnt",      32'(ovf_cnt),      32'd1);

        // Trap-enabled but non-arithmetic ctl (AND) with ovf: no trap.
        ex_pc = 32'h204; alu_out = 32'h0000_00F0; ovf_trap_en = 1'b1; alu_ctl = 4'b0000;
        ex_rd = 5'd11;
        tick();
        chk("and_valid",   32'(mem_valid), 32'd1);
        chk("and_alu_out", mem_alu_out,    32'h0000_00F0);
        chk("and_trap",    32'(trap_req),  32'd0);

        // ---- stall three cycles with an overflowing add presented ----
        stall = 1'b1;
        ovf_add(32'h300);
        alu_out = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid",   32'(mem_valid), 32'd1);
            chk("stall_alu_out", mem_alu_out,    32'h0000_00F0);
            chk("stall_rd",      32'(mem_rd),    32'd11);
            chk("stall_trap",    32'(trap_req),  32'd0);
            chk("stall_exc",     32'(exc_ovf),   32'd0);
        end

        // Flush together with stall: the bubble wins and the hit is ignored.
        flush = 1'b1;
        tick();
        chk("flush_valid",    32'(mem_valid),    32'd0);
        chk("flush_regwrite", 32'(mem_regwrite), 32'd0);
        chk("flush_trap",     32'(trap_req),     32'd0);
        chk("flush_exc",      32'(exc_ovf),      32'd0);
        chk("flush_cnt",      32'(ovf_cnt),      32'd1);
        stall = 1'b0; flush = 1'b0;

        // ---- normal store ----
        ex_valid = 1'b1; ex_pc = 32'h304; alu_out = 32'h1000; alu_ovf = 1'b0;
        ovf_trap_en = 1'b0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memwrite = 1'b1;
        ex_store_data = 32'hDEAD_BEEF;
        tick();
        chk("sw_valid",      32'(mem_valid),    32'd1);
        chk("sw_memwrite",   32'(mem_memwrite), 32'd1);
        chk("sw_store_data", mem_store_data,    32'hDEAD_BEEF);
        chk("sw_regwrite",   32'(mem_regwrite), 32'd0);

        // ---- trap, then reset mid-TRAP ----
        ovf_add(32'h400);
        tick();
        chk("t2_trap", 32'(trap_req), 32'd1);
        chk("t2_epc",  epc,           32'h400);
        chk("t2_cnt",  32'(ovf_cnt),  32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_trap",    32'(trap_req),       32'd0);
        chk("mrst_valid",   32'(mem_valid),      32'd0);
        chk("mrst_alu_out", mem_alu_out,         32'd0);
        chk("mrst_store",   mem_store_data,      32'd0);
        chk("mrst_epc",     epc,                 32'd0);
        chk("mrst_cnt",     32'(ovf_cnt),        32'd0);
        chk("mrst_exc",     32'(exc_ovf),        32'd0);
        // State must be RUN: a normal add loads straight away.
        idle_inputs();
        ex_valid = 1'b1; ex_pc = 32'h500; alu_out = 32'h77; ex_rd = 5'd4; ex_regwrite = 1'b1;
        tick();
        chk("mrst_run_valid", 32'(mem_valid), 32'd1);
        chk("mrst_run_alu",   mem_alu_out,    32'h77);
        chk("mrst_run_trap",  32'(trap_req),  32'd0);

        // ---- saturation: five traps, each acked in its first TRAP cycle ----
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            ovf_add(32'h600 + 32'(k * 4));
            tick();
            chk("sat_cnt",      32'(s_ovf_cnt), sat_exp[k]);
            chk("sat_main_cnt", 32'(ovf_cnt),   32'(k + 1));
            chk("sat_trap",     32'(s_trap_req), 32'd1);
            idle_inputs();
            exc_ack = 1'b1;
            tick();
            chk("sat_ack", 32'(s_trap_req), 32'd0);
        end
        chk("sat_epc", epc, 32'h610);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
